// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store sequencer: opcodes, funct3
// encodings, FSM states and fault causes.
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_DONE  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } cause_t;

  function automatic logic is_mem_opcode(input logic [6:0] op);
    return (op == OPC_LOAD) || (op == OPC_STORE);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-lane replication, access
// legality checks and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic        illegal,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_fmt
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    illegal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = is_store;
      default:          illegal = 1'b1;
    endcase
  end

  // funct3[1:0] encodes the access size for every legal encoding
  always_comb begin
    misaligned  = 1'b0;
    be          = 4'b0000;
    wdata_lanes = 32'h0;
    case (funct3[1:0])
      2'b00: begin
        be          = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned  = addr_lo[0];
        be          = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
      end
      2'b10: begin
        misaligned  = |addr_lo;
        be          = 4'b1111;
        wdata_lanes = wdata;
      end
      default: begin
        misaligned  = 1'b0;
        be          = 4'b0000;
        wdata_lanes = 32'h0;
      end
    endcase
  end

  always_comb begin
    byte_sel = rdata[7:0];
    case (ld_addr_lo)
      2'b00: byte_sel = rdata[7:0];
      2'b01: byte_sel = rdata[15:8];
      2'b10: byte_sel = rdata[23:16];
      2'b11: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_fmt = rdata;
    case (ld_funct3)
      F3_B:    load_fmt = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_fmt = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_fmt = {24'h0, byte_sel};
      F3_HU:   load_fmt = {16'h0, half_sel};
      default: load_fmt = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one memory instruction, runs a req/ack bus
// transaction with timeout, and reports completion or a one-cycle fault.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  state_t      state_reg, state_next;
  cause_t      fault_cause_reg;
  logic        mem_we_reg;
  logic [31:0] mem_addr_reg;
  logic [3:0]  mem_be_reg;
  logic [31:0] mem_wdata_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  addr_lo_reg;
  logic [31:0] load_data_reg;
  logic [31:0] fault_addr_reg;
  logic [7:0]  wait_cnt_reg;

  logic        accept;
  logic        is_store;
  logic        timeout_hit;
  logic [3:0]  be;
  logic [31:0] wdata_lanes;
  logic        illegal;
  logic        misaligned;
  logic [31:0] load_fmt;

  assign is_store    = (opcode == OPC_STORE);
  assign accept      = valid && (state_reg == ST_IDLE) && is_mem_opcode(opcode);
  assign timeout_hit = (wait_cnt_reg == 8'(TIMEOUT - 1));

  lsu_align u_align (
    .is_store    (is_store),
    .funct3      (funct3),
    .addr_lo     (addr[1:0]),
    .wdata       (wdata),
    .be          (be),
    .wdata_lanes (wdata_lanes),
    .illegal     (illegal),
    .misaligned  (misaligned),
    .ld_funct3   (funct3_reg),
    .ld_addr_lo  (addr_lo_reg),
    .rdata       (mem_rdata),
    .load_fmt    (load_fmt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Ack has priority over the timeout on the same edge
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = (illegal || misaligned) ? ST_FAULT : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_next = ST_DONE;
        end else if (timeout_hit) begin
          state_next = ST_FAULT;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_FAULT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_cause_reg <= CAUSE_NONE;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= 32'h0;
      mem_be_reg      <= 4'b0000;
      mem_wdata_reg   <= 32'h0;
      funct3_reg      <= 3'b000;
      addr_lo_reg     <= 2'b00;
      load_data_reg   <= 32'h0;
      fault_addr_reg  <= 32'h0;
      wait_cnt_reg    <= 8'h0;
    end else begin
      if (accept) begin
        wait_cnt_reg   <= 8'h0;
        fault_addr_reg <= addr;
        funct3_reg     <= funct3;
        addr_lo_reg    <= addr[1:0];
        if (illegal) begin
          fault_cause_reg <= CAUSE_ILLEGAL;
        end else if (misaligned) begin
          fault_cause_reg <= CAUSE_MISALIGN;
        end else begin
          mem_we_reg    <= is_store;
          mem_addr_reg  <= {addr[31:2], 2'b00};
          mem_be_reg    <= be;
          mem_wdata_reg <= wdata_lanes;
        end
      end
      if (state_reg == ST_REQ) begin
        if (mem_ack) begin
          if (!mem_we_reg) begin
            load_data_reg <= load_fmt;
          end
        end else if (timeout_hit) begin
          fault_cause_reg <= CAUSE_TIMEOUT;
        end else begin
          wait_cnt_reg <= wait_cnt_reg + 8'h1;
        end
      end
    end
  end

  assign ready       = (state_reg == ST_IDLE);
  assign mem_req     = (state_reg == ST_REQ);
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_be      = mem_be_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign done        = (state_reg == ST_DONE);
  assign fault       = (state_reg == ST_FAULT);
  assign load_data   = load_data_reg;
  assign fault_cause = fault ? fault_cause_reg : 2'b00;
  assign fault_addr  = fault_addr_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed accesses push expectations, a
// negedge monitor checks bus requests and completions against them.
module tb_lsu_ctrl;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic [31:0] load_data;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (valid),
    .opcode      (opcode),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .ready       (ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .done        (done),
    .load_data   (load_data),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fault_addr  (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    bit          is_load;
    logic [31:0] ldata;
    logic [1:0]  cause;
    logic [31:0] faddr;
    int          lat;
    int          reqs;
    bit          has_bus;
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   req_cnt = 0;
  int   txn = 0;
  bit   req_seen = 0;
  bit   prev_cmpl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(bit f, bit ld, logic [31:0] ldv, logic [1:0] c,
                              logic [31:0] fa, int lat, int reqs, bit hb, logic we,
                              logic [31:0] ba, logic [3:0] be, logic [31:0] bw);
    exp_t e;
    e.is_fault = f;   e.is_load = ld;  e.ldata = ldv; e.cause = c;
    e.faddr    = fa;  e.lat     = lat; e.reqs  = reqs;
    e.has_bus  = hb;  e.we      = we;  e.baddr = ba;  e.be = be; e.bwd = bw;
    return e;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      req_cnt   = 0;
      req_seen  = 0;
      prev_cmpl = 0;
    end else begin
      if (prev_cmpl) chk("ready_after_completion", ready, 1);
      prev_cmpl = done || fault;
      if (mem_req) begin
        req_cnt++;
        if (!req_seen) begin
          req_seen = 1;
          if (exp_q.size() == 0 || !exp_q[0].has_bus) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: got mem_req at addr %h expected no request", mem_addr);
          end else begin
            chk("mem_we", mem_we, exp_q[0].we);
            chk("mem_addr", mem_addr, exp_q[0].baddr);
            chk("mem_be", mem_be, exp_q[0].be);
            chk("mem_wdata", mem_wdata, exp_q[0].bwd);
          end
        end
      end
      if (done || fault) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL completion_unexpected: got done=%0d fault=%0d expected none", done, fault);
        end else begin
          mon_e = exp_q.pop_front();
          txn++;
          chk("fault_flag", fault, mon_e.is_fault);
          chk("done_flag", done, !mon_e.is_fault);
          if (mon_e.is_fault) begin
            chk("fault_cause", fault_cause, mon_e.cause);
            chk("fault_addr", fault_addr, mon_e.faddr);
          end else if (mon_e.is_load) begin
            chk("load_data", load_data, mon_e.ldata);
          end
          chk("latency", cyc - acc_cyc, mon_e.lat);
          chk("req_cycles", req_cnt, mon_e.reqs);
          $display("txn %0d: done=%0d fault=%0d cause=%0d load_data=%h latency=%0d req_cycles=%0d",
                   txn, done, fault, fault_cause, load_data, cyc - acc_cyc, req_cnt);
        end
      end
      if (valid && ready && (opcode == LD || opcode == ST)) begin
        acc_cyc  = cyc;
        req_cnt  = 0;
        req_seen = 0;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && !ready; i++) begin
      @(posedge clk); #1;
    end
    chk("wait_ready", ready, 1);
  endtask

  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                     input exp_t e);
    wait_idle();
    exp_q.push_back(e);
    opcode = op; funct3 = f3; addr = a; wdata = wd; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    if (ack_at > 0) begin
      repeat (ack_at - 1) begin
        @(posedge clk); #1;
      end
      mem_ack = 1'b1; mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; opcode = 7'h0; funct3 = 3'h0;
    addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_ready", ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_fault_cause", fault_cause, 0);
    chk("rst_fault_addr", fault_addr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed accesses; TIMEOUT=4
    run(ST, 3'b010, 32'h1000_0008, 32'hDEAD_BEEF, 1, 32'h0,
        mk(0, 0, 32'h0, 2'b00, 32'h0, 2, 1, 1, 1'b1, 32'h1000_0008, 4'b1111, 32'hDEAD_BEEF));
    run(LD, 3'b000, 32'h1000_0002, 32'h0, 1, 32'h1280_3456,
        mk(0, 1, 32'hFFFF_FF80, 2'b00, 32'h0, 2, 1, 1, 1'b0, 32'h1000_0000, 4'b0100, 32'h0));
    run(LD, 3'b100, 32'h1000_0002, 32'h0, 1, 32'h1280_3456,
        mk(0, 1, 32'h0000_0080, 2'b00, 32'h0, 2, 1, 1, 1'b0, 32'h1000_0000, 4'b0100, 32'h0));
    run(ST, 3'b001, 32'h0000_0006, 32'h0000_A5C3, 2, 32'h0,
        mk(0, 0, 32'h0, 2'b00, 32'h0, 3, 2, 1, 1'b1, 32'h0000_0004, 4'b1100, 32'hA5C3_A5C3));
    run(LD, 3'b001, 32'h0000_0005, 32'h0, 0, 32'h0,
        mk(1, 1, 32'h0, 2'b01, 32'h0000_0005, 1, 0, 0, 1'b0, 32'h0, 4'b0, 32'h0));
    run(LD, 3'b010, 32'h0000_0020, 32'h0, 0, 32'h0,
        mk(1, 1, 32'h0, 2'b10, 32'h0000_0020, 5, 4, 1, 1'b0, 32'h0000_0020, 4'b1111, 32'h0));
    run(LD, 3'b010, 32'h0000_0024, 32'h0, 4, 32'hCAFE_F00D,
        mk(0, 1, 32'hCAFE_F00D, 2'b00, 32'h0, 5, 4, 1, 1'b0, 32'h0000_0024, 4'b1111, 32'h0));
    run(LD, 3'b011, 32'h0000_0030, 32'h0, 0, 32'h0,
        mk(1, 1, 32'h0, 2'b11, 32'h0000_0030, 1, 0, 0, 1'b0, 32'h0, 4'b0, 32'h0));
    run(ST, 3'b000, 32'h0000_0013, 32'h0000_005A, 1, 32'h0,
        mk(0, 0, 32'h0, 2'b00, 32'h0, 2, 1, 1, 1'b1, 32'h0000_0010, 4'b1000, 32'h5A5A_5A5A));
    run(LD, 3'b001, 32'h0000_0008, 32'h0, 1, 32'h1234_9ABC,
        mk(0, 1, 32'hFFFF_9ABC, 2'b00, 32'h0, 2, 1, 1, 1'b0, 32'h0000_0008, 4'b0011, 32'h0));
    run(LD, 3'b101, 32'h0000_000A, 32'h0, 1, 32'h8001_7FFF,
        mk(0, 1, 32'h0000_8001, 2'b00, 32'h0, 2, 1, 1, 1'b0, 32'h0000_0008, 4'b1100, 32'h0));
    run(ST, 3'b100, 32'h0000_0001, 32'h0, 0, 32'h0,
        mk(1, 0, 32'h0, 2'b11, 32'h0000_0001, 1, 0, 0, 1'b0, 32'h0, 4'b0, 32'h0));
    run(ST, 3'b010, 32'h0000_0002, 32'h0, 0, 32'h0,
        mk(1, 0, 32'h0, 2'b01, 32'h0000_0002, 1, 0, 0, 1'b0, 32'h0, 4'b0, 32'h0));

    // Non-memory opcode is ignored
    opcode = 7'b0110011; funct3 = 3'b000; addr = 32'h0000_0100; valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("ignored_ready", ready, 1);
      chk("ignored_mem_req", mem_req, 0);
    end
    valid = 1'b0;

    // Reset while a request is outstanding, then a late ack
    exp_q.push_back(mk(0, 1, 32'h0, 2'b00, 32'h0, 2, 1, 1, 1'b0, 32'h0000_0040, 4'b1111, 32'h0));
    opcode = LD; funct3 = 3'b010; addr = 32'h0000_0040; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("pre_reset_mem_req", mem_req, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_mem_req", mem_req, 0);
    chk("reset_ready", ready, 1);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    repeat (3) begin
      @(posedge clk); #1;
      chk("late_ack_done", done, 0);
      chk("late_ack_fault", fault, 0);
    end
    mem_ack = 1'b0;
    chk("late_ack_ready", ready, 1);
    chk("late_ack_load_data", load_data, 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
